// File: rtl/share_splitter.sv
// Splits an unsigned total into num shares that differ by at most one and sum to total.
// The quotient and remainder come from an iterative restoring divider that yields one bit per cycle.
module share_splitter #(
  parameter int DATAWIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] total,
  input  logic [DATAWIDTH-1:0] num,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] share,
  output logic [DATAWIDTH-1:0] share_idx,
  output logic                 share_last,
  output logic                 err,
  output logic                 busy
);

  localparam int CW = $clog2(DATAWIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIV, EMIT, ERR} state_t;

  state_t               state, state_nxt;
  logic [DATAWIDTH-1:0] num_r, dvd, rem, idx;
  logic [CW-1:0]        cnt;
  logic [DATAWIDTH:0]   rem_sh, rem_sub;
  logic                 ge, accept, xfer, last;
  logic [DATAWIDTH-1:0] share_raw;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign err       = (state == ERR);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign rem_sh  = {rem, dvd[DATAWIDTH-1]};
  assign ge      = (rem_sh >= {1'b0, num_r});
  assign rem_sub = rem_sh - {1'b0, num_r};

  // After the divide, dvd holds q and rem holds r; the first r shares carry the extra unit.
  assign share_raw = (idx < rem) ? dvd + DATAWIDTH'(1) : dvd;
  assign last      = (idx == num_r - DATAWIDTH'(1));

  assign share      = out_valid ? share_raw : '0;
  assign share_idx  = out_valid ? idx       : '0;
  assign share_last = out_valid && last;

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (num == '0) ? ERR : DIV;
      DIV:  if (cnt == CW'(DATAWIDTH - 1)) state_nxt = EMIT;
      EMIT: if (xfer && last) state_nxt = IDLE;
      ERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      num_r <= '0;
      dvd   <= '0;
      rem   <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          num_r <= num;
          dvd   <= total;
          rem   <= '0;
          idx   <= '0;
          cnt   <= '0;
        end
        DIV: begin
          dvd <= {dvd[DATAWIDTH-2:0], ge};
          rem <= ge ? rem_sub[DATAWIDTH-1:0] : rem_sh[DATAWIDTH-1:0];
          cnt <= cnt + CW'(1);
          idx <= '0;
        end
        EMIT: if (xfer) idx <= idx + DATAWIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_share_splitter.sv
// Scoreboard bench for share_splitter: stimulus pushes model shares, a negedge monitor checks them.
module tb_share_splitter;

  localparam int W = 16;

  logic         Clk = 0;
  logic         Rst = 1;
  logic         in_valid = 0;
  logic         in_ready;
  logic [W-1:0] total = '0;
  logic [W-1:0] num = '0;
  logic         out_valid;
  logic         out_ready = 1;
  logic [W-1:0] share, share_idx;
  logic         share_last, err, busy;

  share_splitter #(.DATAWIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .total(total), .num(num), .out_valid(out_valid), .out_ready(out_ready),
    .share(share), .share_idx(share_idx), .share_last(share_last),
    .err(err), .busy(busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int sh;
    int idx;
    bit last;
  } exp_t;

  exp_t expq[$];
  int   totq[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   cyc      = 0;
  int   sum      = 0;
  bit   idle_next = 0;
  bit   rdy_rand  = 0;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: q = t/n, r = t%n; the first r shares get q+1.
  task automatic push_exp(input int t, input int n);
    int q, r;
    exp_t e;
    q = t / n;
    r = t % n;
    for (int k = 0; k < n; k++) begin
      e.sh   = (k < r) ? q + 1 : q;
      e.idx  = k;
      e.last = (k == n - 1);
      expq.push_back(e);
    end
    totq.push_back(t);
  endtask

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  initial forever begin
    @(posedge Clk);
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: compare every presented share against the queue head, pop on transfer.
  initial forever begin
    exp_t e;
    @(negedge Clk);
    if (!Rst) begin
      if (idle_next) begin
        chk("in_ready_after_last", int'(in_ready), 1);
        idle_next = 0;
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_share", int'(out_valid), 0);
        end else begin
          e = expq[0];
          chk("share", int'(share), e.sh);
          chk("share_idx", int'(share_idx), e.idx);
          chk("share_last", int'(share_last), int'(e.last));
          if (out_ready) begin
            void'(expq.pop_front());
            sum += int'(share);
            if (e.last) begin
              chk("share_sum", sum, totq.pop_front());
              sum = 0;
              idle_next = 1;
            end
          end
        end
      end else begin
        chk("idle_outputs_zero", int'({share, share_idx, share_last}), 0);
      end
    end
  end

  task automatic send(input int t, input int n);
    int c0, guard;
    @(negedge Clk);
    in_valid = 1;
    total    = W'(t);
    num      = W'(n);
    guard = 0;
    while (!in_ready && guard < 3000) begin
      @(negedge Clk);
      guard++;
    end
    chk("accept_timeout", int'(in_ready), 1);
    c0 = cyc;
    if (n != 0) push_exp(t, n);
    @(negedge Clk);
    in_valid = 0;
    if (n == 0) begin
      chk("err_pulse", int'(err), 1);
      chk("err_no_valid", int'(out_valid), 0);
      chk("err_busy", int'(busy), 1);
      @(negedge Clk);
      chk("err_cleared", int'(err), 0);
      chk("err_in_ready", int'(in_ready), 1);
    end else begin
      while (!out_valid && cyc - c0 < 100) @(negedge Clk);
      chk("latency", cyc - c0, W + 1);
      guard = 0;
      while ((expq.size() != 0 || !in_ready) && guard < 3000) begin
        @(negedge Clk);
        guard++;
      end
      chk("completion_timeout", int'(guard < 3000), 1);
    end
  endtask

  initial begin
    int t, n, guard;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err_busy", int'({err, busy}), 0);
    Rst = 0;
    @(negedge Clk);
    chk("post_rst_outputs", int'({out_valid, share, share_idx, share_last, err, busy}), 0);

    send(100, 8);
    send(5, 8);
    send(65535, 1);
    send(0, 3);
    send(1234, 0);
    rdy_rand = 1;
    send(100, 8);
    send(7, 3);
    rdy_rand = 0;

    // Reset in the middle of emission at share index 3
    @(negedge Clk);
    in_valid = 1; total = 16'd100; num = 16'd8;
    push_exp(100, 8);
    @(negedge Clk);
    in_valid = 0;
    guard = 0;
    do begin
      @(posedge Clk);
      #2;
      guard++;
    end while (!(out_valid && share_idx == 3) && guard < 200);
    chk("reach_idx3", int'(share_idx), 3);
    Rst = 1;
    @(posedge Clk);
    #2;
    Rst = 0;
    expq.delete();
    totq.delete();
    sum = 0;
    idle_next = 0;
    @(negedge Clk);
    chk("midrst_outputs", int'({out_valid, share, share_idx, share_last, err, busy}), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    send(100, 8);

    for (int i = 0; i < 24; i++) begin
      rdy_rand = bit'($urandom_range(0, 1));
      t = int'($urandom_range(0, 65535));
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      if (i % 5 == 4) t = int'($urandom_range(0, 50));
      send(t, n);
    end
    rdy_rand = 0;
    repeat (3) @(negedge Clk);
    chk("queue_drained", expq.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/share_splitter.md
SHARE_SPLITTER -- requirements
Module: share_splitter

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 16, giving the width of total, num and share.
REQ-002 Port Clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port Rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 Port in_valid, input, 1 bit: a request is present on total and num.
REQ-005 Port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 Port total, input, DATAWIDTH bits: unsigned quantity to split.
REQ-007 Port num, input, DATAWIDTH bits: unsigned number of shares.
REQ-008 Port out_valid, output, 1 bit: share, share_idx and share_last are valid.
REQ-009 Port out_ready, input, 1 bit: the consumer takes the current share.
REQ-010 Port share, output, DATAWIDTH bits: current share value.
REQ-011 Port share_idx, output, DATAWIDTH bits: 0-based index of the current share.
REQ-012 Port share_last, output, 1 bit: the current share is number num-1.
REQ-013 Port err, output, 1 bit: one-cycle pulse when a request with num == 0 is rejected.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 The block SHALL be the inverse of the averaging datapath: total is split into num unsigned shares whose sum equals total exactly.
REQ-016 The block SHALL compute q = total / num and r = total % num, both unsigned, truncating division.
REQ-017 Share k SHALL equal q+1 for k < r and q for r <= k < num; no share width overflow is possible, since q+1 <= total whenever r > 0.
REQ-018 The FSM SHALL have four states: IDLE, DIV, EMIT, ERR.
REQ-019 in_ready SHALL be 1 only in IDLE.
REQ-020 A request is accepted on an edge where in_valid && in_ready; total and num SHALL be registered on that edge.
REQ-021 IDLE transitions: accept with num != 0 -> DIV; accept with num == 0 -> ERR; otherwise stay in IDLE.
REQ-022 DIV SHALL run an iterative restoring divider for exactly DATAWIDTH cycles, one quotient bit per cycle (MSB first), then go to EMIT with share index 0.
REQ-023 ERR SHALL last one cycle with err = 1, then return to IDLE; no share is emitted.
REQ-024 In EMIT, out_valid SHALL be 1; a transfer occurs on an edge where out_valid && out_ready.
REQ-025 While out_valid && !out_ready, share, share_idx and share_last SHALL hold stable.
REQ-026 On each transfer the block SHALL increment share_idx; on the transfer with share_last = 1 it SHALL go to IDLE.
REQ-027 Latency: first out_valid SHALL be asserted DATAWIDTH+1 cycles after the accept edge; with out_ready held at 1, one share SHALL transfer per cycle.
REQ-028 in_ready SHALL return to 1 on the cycle after the last transfer; no new request is accepted while EMIT is active.
REQ-029 total == 0 with num != 0 SHALL emit num shares, all 0.
REQ-030 num == 1 SHALL emit one share equal to total, with share_last = 1.
REQ-031 When out_valid = 0, share, share_idx and share_last SHALL be 0.

Reset
REQ-032 Rst = 1 SHALL force IDLE on the next edge from any state, including mid-DIV and mid-EMIT; the operation in flight is discarded.
REQ-033 After reset, outputs SHALL be: in_ready = 1, out_valid = 0, share = 0, share_idx = 0, share_last = 0, err = 0, busy = 0.
REQ-034 Rst SHALL take priority over any handshake in the same cycle.

Verification
REQ-035 total=100, num=8, out_ready=1 -> shares 13,13,13,13,12,12,12,12; share_last on index 7; first out_valid 17 cycles after accept.
REQ-036 total=5, num=8 -> shares 1,1,1,1,1,0,0,0; sum of shares = 5.
REQ-037 total=65535, num=1 -> single share 65535 with share_last = 1; in_ready = 1 on the following cycle.
REQ-038 num=0, any total -> err = 1 for exactly one cycle, out_valid never asserted, in_ready = 1 two cycles after accept.
REQ-039 total=100, num=8, out_ready toggled 0/1 randomly -> same share sequence as REQ-035, outputs stable during every stall, no share lost or duplicated.
REQ-040 Rst asserted during EMIT at share_idx=3 -> next cycle out_valid=0, in_ready=1, all outputs 0; a new request then completes normally.
